dkong_audio_out: RTL
====================

Name: dkong_audio_out

Overview:
- Output stage directly downstream of the Donkey Kong soundboard mixer.
- Consumes the signed 16-bit mixed sample and its 48 kHz sample strobe, then processes each sample in order:
  - first-order DC-blocking high-pass filter;
  - saturating 4-bit volume gain and mute;
  - 4-entry FIFO.
- Delivers samples to the platform audio interface over a valid/ready handshake in the same clock domain.

Parameters:
- DC_SHIFT, 8, high-pass pole: y_prev decays by y_prev>>>DC_SHIFT per sample (8 gives a 255/256 pole).
- FIFO_DEPTH, 4, number of FIFO entries. Must be a power of two, ≥2.

Ports:
- W_CLK_24M  in  1  system clock, 24 MHz.
- W_RESETn  in  1  reset; asynchronous assert, active-low.
- I_SAMPLE  in  16  signed mixed sample from the soundboard.
- I_SAMPLE_EN  in  1  one-cycle strobe; I_SAMPLE is valid in that cycle.
- I_VOL  in  4  unsigned gain; 8 = unity; gain = I_VOL/8.
- I_MUTE  in  1  forces processed output to 0.
- O_DATA  out  16  signed FIFO head sample.
- O_VALID  out  1  FIFO not empty.
- I_READY  in  1  consumer accepts O_DATA when O_VALID & I_READY.
- O_OVF  out  1  sticky overflow flag.

Behaviour:

Reset (W_RESETn=0, asynchronous):
- x_prev, y_prev, gain register, FIFO pointers and count all clear to 0.
- O_DATA=0, O_VALID=0, O_OVF=0.
- Applies mid-operation: all queued samples are discarded.

Stage 1, DC blocker (edge where I_SAMPLE_EN=1, cycle N):
- Computes y = I_SAMPLE − x_prev + y_prev − (y_prev>>>DC_SHIFT).
- Arithmetic is 19-bit signed; the result saturates to 18-bit signed [−131072, 131071].
- y_prev←y and x_prev←I_SAMPLE; s1_valid pulses for one cycle.
- No strobe: the filter state holds.

Stage 2, gain (cycle N+1, when s1_valid=1):
- Computes p = (y_prev × I_VOL) >>> 3, with 23-bit signed product and arithmetic shift.
- p saturates to [−32768, 32767] and is registered as g, with g_valid pulsing.
- I_VOL is sampled in this cycle.
- I_MUTE=1: g=0, but g_valid still pulses and the filter state keeps updating.

Stage 3, FIFO write (cycle N+2, when g_valid=1):
- FIFO not full: g is written at wr_ptr; wr_ptr and count increment.
- FIFO full and no simultaneous pop: g is dropped (newest discarded) and O_OVF←1. O_OVF stays set until reset.
- FIFO full with a simultaneous pop (O_VALID & I_READY): the push succeeds with no overflow, and count is unchanged.

Read side:
- O_DATA is mem[rd_ptr], taken from registered storage.
- O_VALID = (count ≠ 0).
- A pop occurs on O_VALID & I_READY and advances rd_ptr.
- Pointers wrap modulo FIFO_DEPTH.
- I_READY while empty has no effect.
- Simultaneous push and pop on a non-empty FIFO leaves count unchanged.

Latency and throughput:
- Strobe at edge N; sample visible on O_DATA with O_VALID=1 after edge N+2 (3 cycles, FIFO previously empty).
- Strobes arrive every 500 cycles. Two strobes one cycle apart are still handled in order: each stage is a single-cycle pulse pipeline with no stall.

Test Plan:
- Reset: hold W_RESETn=0 while I_SAMPLE_EN toggles → O_VALID=0, O_DATA=0, O_OVF=0; after release, first strobe yields O_VALID=1 exactly 3 edges later.
- DC step (I_VOL=8, I_READY=1, DC_SHIFT=8): I_SAMPLE=1000 on 3 strobes → outputs 1000, 997, 994; subsequent outputs decay monotonically toward 0.
- Saturation: I_VOL=15, I_SAMPLE=+20000 from reset → 37500 saturates to 32767. Next strobe with I_SAMPLE=−20000: y=−40000+19922=−20078 → −37647 saturates to −32768.
- Overflow: I_READY=0, 5 strobes of 100,200,300,400,500 (I_VOL=8, DC_SHIFT large) → count=4, O_OVF=1; popping yields the first four in order (500 dropped); O_OVF remains 1 until reset.
- Mute and simultaneous events:
  - I_MUTE=1 across strobes → O_DATA=0 and O_VALID still pulses per sample; filter state advances.
  - With the FIFO full, a push and pop in the same cycle → no overflow and order preserved.
- Reset mid-operation: 3 samples queued, then W_RESETn pulsed low between pipeline stages → O_VALID drops immediately, FIFO empty; the next strobe after release produces filter output equal to I_SAMPLE×I_VOL/8.

Source files
------------

// File: rtl/dkong_audio_out_if.sv
// Sample-in / audio-out bundle for the soundboard output stage.
// The slave side is the output stage; the master side is the mixer plus platform audio sink.
interface dkong_audio_out_if;
  logic signed [15:0] sample;
  logic               sample_en;
  logic        [3:0]  vol;
  logic               mute;
  logic signed [15:0] data;
  logic               valid;
  logic               ready;
  logic               ovf;

  modport master (
    output sample, sample_en, vol, mute, ready,
    input  data, valid, ovf
  );

  modport slave (
    input  sample, sample_en, vol, mute, ready,
    output data, valid, ovf
  );
endinterface

// File: rtl/dkong_audio_out.sv
// Donkey Kong audio output stage: DC-blocking high-pass, saturating volume/mute,
// and a small FIFO feeding a valid/ready consumer in the same clock domain.
module dkong_audio_out #(
  parameter int unsigned DcShift   = 8,
  parameter int unsigned FifoDepth = 4
) (
  input  logic              w_clk_24m_i,
  input  logic              w_resetn_i,
  dkong_audio_out_if.slave  aud_if
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;

  // Stage 1: DC blocker
  logic signed [15:0] x_prev_q, x_prev_d;
  logic signed [17:0] y_prev_q, y_prev_d;
  logic               s1_valid_q;
  logic signed [17:0] y_decay;
  logic signed [18:0] dc_sum;

  assign y_decay = y_prev_q >>> DcShift;
  assign dc_sum  = {{3{aud_if.sample[15]}}, aud_if.sample}
                 - {{3{x_prev_q[15]}}, x_prev_q}
                 + {y_prev_q[17], y_prev_q}
                 - {y_decay[17], y_decay};

  always_comb begin
    x_prev_d = x_prev_q;
    y_prev_d = y_prev_q;
    if (aud_if.sample_en) begin
      x_prev_d = aud_if.sample;
      if (dc_sum[18] != dc_sum[17]) begin
        y_prev_d = dc_sum[18] ? 18'sh20000 : 18'sh1ffff;
      end else begin
        y_prev_d = dc_sum[17:0];
      end
    end
  end

  always_ff @(posedge w_clk_24m_i or negedge w_resetn_i) begin
    if (!w_resetn_i) begin
      x_prev_q   <= '0;
      y_prev_q   <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      x_prev_q   <= x_prev_d;
      y_prev_q   <= y_prev_d;
      s1_valid_q <= aud_if.sample_en;
    end
  end

  // Stage 2: gain = vol/8 applied to the freshly updated filter output
  logic signed [22:0] prod;
  logic signed [22:0] prod_shr;
  logic signed [15:0] p_sat;
  logic signed [15:0] g_q, g_d;
  logic               g_valid_q;

  assign prod     = {{5{y_prev_q[17]}}, y_prev_q} * $signed({19'd0, aud_if.vol});
  assign prod_shr = prod >>> 3;

  always_comb begin
    if ((&prod_shr[22:15]) || !(|prod_shr[22:15])) begin
      p_sat = prod_shr[15:0];
    end else begin
      p_sat = prod_shr[22] ? 16'sh8000 : 16'sh7fff;
    end
    g_d = g_q;
    if (s1_valid_q) begin
      g_d = aud_if.mute ? 16'sd0 : p_sat;
    end
  end

  always_ff @(posedge w_clk_24m_i or negedge w_resetn_i) begin
    if (!w_resetn_i) begin
      g_q       <= '0;
      g_valid_q <= 1'b0;
    end else begin
      g_q       <= g_d;
      g_valid_q <= s1_valid_q;
    end
  end

  // Stage 3: FIFO
  logic signed [15:0] mem_q [FifoDepth];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               full, pop, push_ok;

  assign full    = (count_q == CntW'(FifoDepth));
  assign pop     = (count_q != '0) && aud_if.ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok = g_valid_q && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end
    if (g_valid_q && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge w_clk_24m_i or negedge w_resetn_i) begin
    if (!w_resetn_i) begin
      for (int i = 0; i < int'(FifoDepth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= g_q;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign aud_if.data  = mem_q[rd_ptr_q];
  assign aud_if.valid = (count_q != '0);
  assign aud_if.ovf   = ovf_q;

endmodule
